asi_port_arb: RTL and testbench

ASI_PORT_ARB -- requirements
Module: asi_port_arb

---
 rtl/asi_pkg.sv | 22 ++
 rtl/asi_sat_cnt.sv | 24 ++
 rtl/asi_port_arb.sv | 136 +++++++++++++
 tb/tb_asi_port_arb.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asi_pkg.sv
// Shared types for the ASI port: arbiter states and requester sides,
// used by the arbiter and by the read/write side logic.
package asi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } arb_state_e;

    typedef enum logic {
        RGNT = 1'b0,
        WGNT = 1'b1
    } side_e;

    localparam logic [3:0] STREAK_SAT = 4'd15;

    function automatic side_e other_side(side_e s);
        return (s == RGNT) ? WGNT : RGNT;
    endfunction

endpackage

// File: rtl/asi_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module asi_sat_cnt #(
    parameter int W = 16
) (
    input  logic         usr_clk,
    input  logic         usr_reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/asi_port_arb.sv
// Read/write burst arbiter for the shared ASI port: burst-granular grants,
// a preferred side with a starvation limit, and grant statistics.
module asi_port_arb
    import asi_pkg::*;
#(
    parameter int AXI_AW     = 40,
    parameter int SLV_ARB    = 0,
    parameter int STARVE_MAX = 4,
    parameter int CNTW       = 16
) (
    input  logic              usr_clk,
    input  logic              usr_reset_n,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic              rd_beat,
    input  logic              rd_last,
    input  logic              wr_beat,
    input  logic              wr_last,
    input  logic [AXI_AW-1:0] rd_addr,
    input  logic [AXI_AW-1:0] wr_addr,
    output logic              rgnt,
    output logic              wgnt,
    output logic [AXI_AW-1:0] m_addr,
    input  logic              stat_clr,
    output logic [CNTW-1:0]   rd_bursts,
    output logic [CNTW-1:0]   wr_bursts,
    output logic [CNTW-1:0]   starve_hits,
    output logic              proto_err,
    output logic [1:0]        dbg_state
);

    localparam side_e      PREF       = (SLV_ARB != 0) ? RGNT : WGNT;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_e state;
    arb_state_e state_nxt;
    side_e      last_side;
    side_e      grant_side;
    logic [3:0] streak;
    logic       decision;
    logic       grant_new;
    logic       forced;

    // A burst only ends on the qualified last beat of the granted side;
    // stray beats from the other side never move the state.
    always_comb begin
        decision   = (state == IDLE) ||
                     ((state == READ)  && rd_beat && rd_last) ||
                     ((state == WRITE) && wr_beat && wr_last);
        grant_new  = 1'b0;
        grant_side = PREF;
        forced     = 1'b0;
        state_nxt  = state;
        if (decision) begin
            if (rd_req && wr_req) begin
                grant_new = 1'b1;
                if ((last_side == PREF) && (streak >= STARVE_LIM)) begin
                    grant_side = other_side(PREF);
                    forced     = 1'b1;
                end
            end else if (rd_req) begin
                grant_new  = 1'b1;
                grant_side = RGNT;
            end else if (wr_req) begin
                grant_new  = 1'b1;
                grant_side = WGNT;
            end
            if (!grant_new) begin
                state_nxt = IDLE;
            end else if (grant_side == RGNT) begin
                state_nxt = READ;
            end else begin
                state_nxt = WRITE;
            end
        end
    end

    // Streak and last side survive IDLE so fairness spans idle gaps.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            state     <= IDLE;
            rgnt      <= 1'b0;
            wgnt      <= 1'b0;
            last_side <= WGNT;
            streak    <= 4'd0;
        end else begin
            state <= state_nxt;
            rgnt  <= (state_nxt == READ);
            wgnt  <= (state_nxt == WRITE);
            if (grant_new) begin
                last_side <= grant_side;
                if (grant_side != last_side) begin
                    streak <= 4'd1;
                end else if (streak != STREAK_SAT) begin
                    streak <= streak + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            proto_err <= 1'b0;
        end else if ((rd_beat && !rgnt) || (wr_beat && !wgnt)) begin
            proto_err <= 1'b1;
        end
    end

    assign m_addr    = wgnt ? wr_addr : rd_addr;
    assign dbg_state = state;

    asi_sat_cnt #(.W(CNTW)) u_rd_cnt (
        .usr_clk     (usr_clk),
        .usr_reset_n (usr_reset_n),
        .clr         (stat_clr),
        .inc         (grant_new && (grant_side == RGNT)),
        .cnt         (rd_bursts)
    );

    asi_sat_cnt #(.W(CNTW)) u_wr_cnt (
        .usr_clk     (usr_clk),
        .usr_reset_n (usr_reset_n),
        .clr         (stat_clr),
        .inc         (grant_new && (grant_side == WGNT)),
        .cnt         (wr_bursts)
    );

    asi_sat_cnt #(.W(CNTW)) u_starve_cnt (
        .usr_clk     (usr_clk),
        .usr_reset_n (usr_reset_n),
        .clr         (stat_clr),
        .inc         (grant_new && forced),
        .cnt         (starve_hits)
    );

endmodule

// File: tb/tb_asi_port_arb.sv
// Bench for asi_port_arb: directed scenarios plus randomized traffic against
// a cycle-level model of the arbitration rules.
module tb_asi_port_arb;

  localparam int AW = 40;
  localparam int PREF = 2;  // SLV_ARB=0: write side preferred (1=read, 2=write)
  localparam int STARVE_MAX = 4;

  // clock/reset
  logic usr_clk;
  logic usr_reset_n;
  initial usr_clk = 1'b0;
  always #5 usr_clk = ~usr_clk;

  logic rd_req, wr_req, rd_beat, rd_last, wr_beat, wr_last, stat_clr;
  logic [AW-1:0] rd_addr, wr_addr, m_addr, s_m_addr;
  logic rgnt, wgnt, proto_err, s_rgnt, s_wgnt, s_proto_err;
  logic [15:0] rd_bursts, wr_bursts, starve_hits;
  logic [7:0] s_rd_bursts, s_wr_bursts, s_starve_hits;
  logic [1:0] dbg_state, s_dbg_state;

  asi_port_arb #(.AXI_AW(AW), .SLV_ARB(0), .STARVE_MAX(STARVE_MAX), .CNTW(16)) u_dut (
    .usr_clk(usr_clk), .usr_reset_n(usr_reset_n),
    .rd_req(rd_req), .wr_req(wr_req),
    .rd_beat(rd_beat), .rd_last(rd_last), .wr_beat(wr_beat), .wr_last(wr_last),
    .rd_addr(rd_addr), .wr_addr(wr_addr),
    .rgnt(rgnt), .wgnt(wgnt), .m_addr(m_addr),
    .stat_clr(stat_clr), .rd_bursts(rd_bursts), .wr_bursts(wr_bursts),
    .starve_hits(starve_hits), .proto_err(proto_err), .dbg_state(dbg_state)
  );

  // narrow-counter copy so counter saturation is reachable quickly
  asi_port_arb #(.AXI_AW(AW), .SLV_ARB(0), .STARVE_MAX(STARVE_MAX), .CNTW(8)) u_sat (
    .usr_clk(usr_clk), .usr_reset_n(usr_reset_n),
    .rd_req(rd_req), .wr_req(wr_req),
    .rd_beat(rd_beat), .rd_last(rd_last), .wr_beat(wr_beat), .wr_last(wr_last),
    .rd_addr(rd_addr), .wr_addr(wr_addr),
    .rgnt(s_rgnt), .wgnt(s_wgnt), .m_addr(s_m_addr),
    .stat_clr(stat_clr), .rd_bursts(s_rd_bursts), .wr_bursts(s_wr_bursts),
    .starve_hits(s_starve_hits), .proto_err(s_proto_err), .dbg_state(s_dbg_state)
  );

  int n_tests = 0;
  int n_fail = 0;

  // reference model: granted side (0 none, 1 read, 2 write), fairness history, unsaturated counts
  int m_state, m_last, m_streak, m_rd, m_wr, m_starve;
  bit m_perr;

  function automatic logic [15:0] sat16(int c);
    logic [31:0] v;
    v = c;
    return (c > 65535) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [7:0] sat8(int c);
    logic [31:0] v;
    v = c;
    return (c > 255) ? 8'hFF : v[7:0];
  endfunction

  task automatic model_reset();
    m_state = 0; m_last = 2; m_streak = 0;
    m_rd = 0; m_wr = 0; m_starve = 0; m_perr = 1'b0;
  endtask

  task automatic model_step();
    int g;
    bit dec;
    if ((rd_beat && m_state != 1) || (wr_beat && m_state != 2)) m_perr = 1'b1;
    dec = (m_state == 0) || (m_state == 1 && rd_beat && rd_last) ||
          (m_state == 2 && wr_beat && wr_last);
    if (dec) begin
      g = 0;
      if (rd_req && wr_req) begin
        if (m_last == PREF && m_streak >= STARVE_MAX) begin
          g = 3 - PREF;
          m_starve++;
        end else begin
          g = PREF;
        end
      end else if (rd_req) g = 1;
      else if (wr_req) g = 2;
      if (g != 0) begin
        m_streak = (g == m_last) ? ((m_streak < 15) ? m_streak + 1 : 15) : 1;
        m_last = g;
        if (g == 1) m_rd++; else m_wr++;
      end
      m_state = g;
    end
    if (stat_clr) begin
      m_rd = 0; m_wr = 0; m_starve = 0;
    end
  endtask

  // driver tasks
  task automatic tick();
    model_step();
    @(posedge usr_clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_req = 0; wr_req = 0; rd_beat = 0; rd_last = 0; wr_beat = 0; wr_last = 0;
    stat_clr = 0;
    rd_addr = {8'h11, 32'h2222_3333};
    wr_addr = {8'hAA, 32'hBBBB_CCCC};
  endtask

  task automatic do_reset();
    clear_inputs();
    usr_reset_n = 0;
    model_reset();
    @(posedge usr_clk);
    #1;
    @(posedge usr_clk);
    #2;
    usr_reset_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    usr_reset_n = 0;
    model_reset();
    #7;
    n_tests++;
    if (rgnt !== 0 || wgnt !== 0 || proto_err !== 0) begin
      n_fail++;
      $display("FAIL reset_grants: rgnt=%b wgnt=%b proto_err=%b, required 0 0 0", rgnt, wgnt, proto_err);
    end
    n_tests++;
    if (rd_bursts !== 16'd0 || wr_bursts !== 16'd0 || starve_hits !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters: rd=%0h wr=%0h starve=%0h, required 0", rd_bursts, wr_bursts, starve_hits);
    end
    @(posedge usr_clk);
    #2;
    usr_reset_n = 1;
    tick();
    n_tests++;
    if (rgnt !== 0 || wgnt !== 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: rgnt=%b wgnt=%b, required 0 0", rgnt, wgnt);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    rd_req = 1;
    tick();
    n_tests++;
    if (rgnt !== 1 || wgnt !== 0 || rd_bursts !== 16'd1) begin
      n_fail++;
      $display("FAIL read_grant: rgnt=%b wgnt=%b rd_bursts=%0d, required 1 0 1", rgnt, wgnt, rd_bursts);
    end
    rd_req = 0;  // request drops mid-burst; grant must hold
    for (int b = 0; b < 3; b++) begin
      rd_beat = 1;
      rd_last = (b == 2);
      tick();
      n_tests++;
      if (rgnt !== (b != 2)) begin
        n_fail++;
        $display("FAIL read_burst_beat%0d: rgnt=%b, required %b", b, rgnt, (b != 2));
      end
    end
    rd_beat = 0; rd_last = 0;
    n_tests++;
    if (rd_bursts !== 16'd1 || proto_err !== 0) begin
      n_fail++;
      $display("FAIL read_burst_count: rd_bursts=%0d proto_err=%b, required 1 0", rd_bursts, proto_err);
    end
  endtask

  task automatic test_starve();
    do_reset();
    rd_req = 1; wr_req = 1;
    tick();
    for (int g = 0; g < 15; g++) begin
      n_tests++;
      if (wgnt !== (g % 5 != 4) || rgnt !== (g % 5 == 4)) begin
        n_fail++;
        $display("FAIL starve_pattern%0d: rgnt=%b wgnt=%b, required %b %b", g, rgnt, wgnt, (g % 5 == 4), (g % 5 != 4));
      end
      n_tests++;
      if (starve_hits !== 16'((g + 1) / 5)) begin
        n_fail++;
        $display("FAIL starve_hits%0d: got %0d, required %0d", g, starve_hits, (g + 1) / 5);
      end
      rd_beat = (m_state == 1); rd_last = (m_state == 1);
      wr_beat = (m_state == 2); wr_last = (m_state == 2);
      tick();
    end
    rd_req = 0; wr_req = 0;
    rd_beat = (m_state == 1); rd_last = (m_state == 1);
    wr_beat = (m_state == 2); wr_last = (m_state == 2);
    tick();
    rd_beat = 0; rd_last = 0; wr_beat = 0; wr_last = 0;
    n_tests++;
    if (rgnt !== 0 || wgnt !== 0 || wr_bursts !== 16'(m_wr) || rd_bursts !== 16'(m_rd)) begin
      n_fail++;
      $display("FAIL starve_totals: rd=%0d wr=%0d, required %0d %0d", rd_bursts, wr_bursts, m_rd, m_wr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rd_req = 1;
    tick();
    n_tests++;
    if (m_addr !== rd_addr) begin
      n_fail++;
      $display("FAIL b2b_rd_addr: m_addr=%0h, required %0h", m_addr, rd_addr);
    end
    rd_req = 0; wr_req = 1;
    rd_beat = 1; rd_last = 1;
    tick();
    rd_beat = 0; rd_last = 0;
    n_tests++;
    if (wgnt !== 1 || rgnt !== 0) begin
      n_fail++;
      $display("FAIL b2b_switch: rgnt=%b wgnt=%b, required 0 1", rgnt, wgnt);
    end
    n_tests++;
    if (m_addr !== wr_addr) begin
      n_fail++;
      $display("FAIL b2b_wr_addr: m_addr=%0h, required %0h", m_addr, wr_addr);
    end
    wr_req = 0; wr_beat = 1; wr_last = 1;
    tick();
    wr_beat = 0; wr_last = 0;
  endtask

  task automatic test_proto_err();
    do_reset();
    rd_req = 1;
    tick();
    rd_req = 0;
    wr_beat = 1; wr_last = 1;
    tick();
    wr_beat = 0; wr_last = 0;
    n_tests++;
    if (proto_err !== 1 || rgnt !== 1 || wgnt !== 0) begin
      n_fail++;
      $display("FAIL proto_err_set: proto_err=%b rgnt=%b wgnt=%b, required 1 1 0", proto_err, rgnt, wgnt);
    end
    tick();
    tick();
    n_tests++;
    if (proto_err !== 1 || rgnt !== 1) begin
      n_fail++;
      $display("FAIL proto_err_sticky: proto_err=%b rgnt=%b, required 1 1", proto_err, rgnt);
    end
    rd_beat = 1; rd_last = 1;
    tick();
    rd_beat = 0; rd_last = 0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    wr_req = 1;
    tick();
    wr_beat = 1; wr_last = 0;
    tick();
    n_tests++;
    if (wgnt !== 1 || wr_bursts !== 16'd1) begin
      n_fail++;
      $display("FAIL mid_burst_setup: wgnt=%b wr_bursts=%0d, required 1 1", wgnt, wr_bursts);
    end
    usr_reset_n = 0;
    #1;
    n_tests++;
    if (wgnt !== 0 || rgnt !== 0 || wr_bursts !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: wgnt=%b rgnt=%b wr_bursts=%0d, required 0 0 0", wgnt, rgnt, wr_bursts);
    end
    model_reset();
    clear_inputs();
    rd_req = 1;
    #1;
    usr_reset_n = 1;
    tick();
    n_tests++;
    if (rgnt !== 1 || wgnt !== 0 || rd_bursts !== 16'd1) begin
      n_fail++;
      $display("FAIL read_after_reset: rgnt=%b wgnt=%b rd_bursts=%0d, required 1 0 1", rgnt, wgnt, rd_bursts);
    end
    rd_req = 0; rd_beat = 1; rd_last = 1;
    tick();
    rd_beat = 0; rd_last = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    rd_req = 1;
    tick();
    rd_beat = 1; rd_last = 1;
    for (int i = 0; i < 300; i++) tick();
    n_tests++;
    if (s_rd_bursts !== 8'hFF) begin
      n_fail++;
      $display("FAIL sat_hold: rd_bursts=%0h, required ff", s_rd_bursts);
    end
    n_tests++;
    if (rd_bursts !== sat16(m_rd)) begin
      n_fail++;
      $display("FAIL sat_wide_count: rd_bursts=%0d, required %0d", rd_bursts, sat16(m_rd));
    end
    stat_clr = 1;
    tick();
    stat_clr = 0;
    n_tests++;
    if (s_rd_bursts !== 8'd0 || rd_bursts !== 16'd0) begin
      n_fail++;
      $display("FAIL sat_clear: narrow=%0h wide=%0h, required 0 0", s_rd_bursts, rd_bursts);
    end
    tick();
    n_tests++;
    if (rd_bursts !== 16'd1 || s_rd_bursts !== 8'd1) begin
      n_fail++;
      $display("FAIL count_after_clear: wide=%0d narrow=%0d, required 1 1", rd_bursts, s_rd_bursts);
    end
    rd_req = 0;
    tick();
    rd_beat = 0; rd_last = 0;
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 1500; c++) begin
      rd_req = ($urandom_range(0, 3) != 0);
      wr_req = ($urandom_range(0, 3) != 0);
      rd_addr = {8'($urandom), $urandom};
      wr_addr = {8'($urandom), $urandom};
      rd_beat = (m_state == 1) && ($urandom_range(0, 1) == 1);
      rd_last = ($urandom_range(0, 2) == 0);
      wr_beat = (m_state == 2) && ($urandom_range(0, 1) == 1);
      wr_last = ($urandom_range(0, 2) == 0);
      stat_clr = ($urandom_range(0, 99) == 0);
      tick();
      n_tests++;
      if (rgnt !== (m_state == 1) || wgnt !== (m_state == 2)) begin
        n_fail++;
        if (errs++ < 10) $display("FAIL rand_grant c%0d: rgnt=%b wgnt=%b, required %b %b", c, rgnt, wgnt, (m_state == 1), (m_state == 2));
      end
      n_tests++;
      if (m_addr !== ((m_state == 2) ? wr_addr : rd_addr)) begin
        n_fail++;
        if (errs++ < 10) $display("FAIL rand_addr c%0d: m_addr=%0h", c, m_addr);
      end
      n_tests++;
      if (rd_bursts !== sat16(m_rd) || wr_bursts !== sat16(m_wr) || starve_hits !== sat16(m_starve)) begin
        n_fail++;
        if (errs++ < 10) $display("FAIL rand_counts c%0d: rd=%0d wr=%0d st=%0d, required %0d %0d %0d", c, rd_bursts, wr_bursts, starve_hits, m_rd, m_wr, m_starve);
      end
      n_tests++;
      if (proto_err !== m_perr) begin
        n_fail++;
        if (errs++ < 10) $display("FAIL rand_proto c%0d: proto_err=%b, required %b", c, proto_err, m_perr);
      end
    end
    n_tests++;
    if (s_wr_bursts !== sat8(m_wr)) begin
      n_fail++;
      $display("FAIL rand_narrow_wr: got %0d, required %0d", s_wr_bursts, sat8(m_wr));
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_starve();
    test_back_to_back();
    test_proto_err();
    test_reset_mid_burst();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
